// File: rtl/operand_fetch.sv
// Operand fetch stage: resolves source operands from x0 / EX forward / WB
// bypass / regfile, stalls on load-use and back-to-back hazards using a
// pending-load scoreboard, and registers the result into the ID/EX register.
module operand_fetch #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [4:0]   in_rs1,
   input  logic [4:0]   in_rs2,
   input  logic         in_rs1_en,
   input  logic         in_rs2_en,
   input  logic [4:0]   in_rd,
   input  logic         in_rd_we,
   input  logic         in_is_load,
   input  logic [N-1:0] in_pc,
   input  logic [N-1:0] in_imm,
   output logic [4:0]   rf_rs1,
   output logic [4:0]   rf_rs2,
   input  logic [N-1:0] rf_rdata1,
   input  logic [N-1:0] rf_rdata2,
   input  logic         ex_fwd_valid,
   input  logic [4:0]   ex_fwd_rd,
   input  logic [N-1:0] ex_fwd_data,
   input  logic         wb_we,
   input  logic [4:0]   wb_rd,
   input  logic [N-1:0] wb_data,
   input  logic         wb_is_load,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_rs1_data,
   output logic [N-1:0] out_rs2_data,
   output logic [4:0]   out_rd,
   output logic         out_rd_we,
   output logic         out_is_load,
   output logic [N-1:0] out_pc,
   output logic [N-1:0] out_imm
);

   logic         r_valid;
   logic [N-1:0] r_rs1_data;
   logic [N-1:0] r_rs2_data;
   logic [4:0]   r_rd;
   logic         r_rd_we;
   logic         r_is_load;
   logic [N-1:0] r_pc;
   logic [N-1:0] r_imm;
   logic [31:0]  r_pending;

   logic [N-1:0] w_rs1_val;
   logic [N-1:0] w_rs2_val;
   logic         w_ld_done;
   logic         w_haz1;
   logic         w_haz2;
   logic         w_accept;
   logic         w_out_fire;
   logic [31:0]  w_pending_nxt;

   assign rf_rs1 = in_rs1;
   assign rf_rs2 = in_rs2;

   assign w_ld_done = wb_we && wb_is_load;

   // Operand select: x0, then EX forward, then WB bypass (write lands at this edge), then regfile
   always_comb begin
      w_rs1_val = rf_rdata1;
      if (in_rs1 == 5'd0)                             w_rs1_val = '0;
      else if (ex_fwd_valid && ex_fwd_rd == in_rs1)   w_rs1_val = ex_fwd_data;
      else if (wb_we && wb_rd == in_rs1)              w_rs1_val = wb_data;
      w_rs2_val = rf_rdata2;
      if (in_rs2 == 5'd0)                             w_rs2_val = '0;
      else if (ex_fwd_valid && ex_fwd_rd == in_rs2)   w_rs2_val = ex_fwd_data;
      else if (wb_we && wb_rd == in_rs2)              w_rs2_val = wb_data;
   end

   // Hazard per source: load outstanding (unless it completes now), or producer still in ID/EX
   always_comb begin
      w_haz1 = in_rs1_en && (in_rs1 != 5'd0) &&
               ((r_pending[in_rs1] && !(w_ld_done && wb_rd == in_rs1)) ||
                (r_valid && r_rd_we && r_rd == in_rs1));
      w_haz2 = in_rs2_en && (in_rs2 != 5'd0) &&
               ((r_pending[in_rs2] && !(w_ld_done && wb_rd == in_rs2)) ||
                (r_valid && r_rd_we && r_rd == in_rs2));
   end

   assign in_ready   = !rst && !flush && !w_haz1 && !w_haz2 && (!r_valid || out_ready);
   assign w_accept   = in_valid && in_ready;
   // A flushed instruction is killed, so it never counts as consumed by execute
   assign w_out_fire = r_valid && out_ready && !flush;

   // Scoreboard next state: clear on load completion, then set on load handoff (set wins)
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_ld_done)
         w_pending_nxt[wb_rd] = 1'b0;
      if (w_out_fire && r_is_load && r_rd_we && r_rd != 5'd0)
         w_pending_nxt[r_rd] = 1'b1;
      w_pending_nxt[0] = 1'b0;
   end

   // Pending-load scoreboard register
   always_ff @(posedge clk) begin
      if (rst) r_pending <= '0;
      else     r_pending <= w_pending_nxt;
   end

   // ID/EX register: flush kills, accept loads, consume drains, otherwise hold
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_rd       <= '0;
         r_rd_we    <= 1'b0;
         r_is_load  <= 1'b0;
         r_pc       <= '0;
         r_imm      <= '0;
      end else if (flush) begin
         r_valid    <= 1'b0;
      end else if (w_accept) begin
         r_valid    <= 1'b1;
         r_rs1_data <= w_rs1_val;
         r_rs2_data <= w_rs2_val;
         r_rd       <= in_rd;
         r_rd_we    <= in_rd_we;
         r_is_load  <= in_is_load;
         r_pc       <= in_pc;
         r_imm      <= in_imm;
      end else if (out_ready) begin
         r_valid    <= 1'b0;
      end
   end

   assign out_valid    = r_valid;
   assign out_rs1_data = r_rs1_data;
   assign out_rs2_data = r_rs2_data;
   assign out_rd       = r_rd;
   assign out_rd_we    = r_rd_we;
   assign out_is_load  = r_is_load;
   assign out_pc       = r_pc;
   assign out_imm      = r_imm;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus randomized traffic, all
// checked against a behavioural model (operand rules, pending-load set, regfile array).
module tb_operand_fetch;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, in_rs1_en, in_rs2_en, in_rd_we, in_is_load;
   logic [4:0]   in_rs1, in_rs2, in_rd, rf_rs1, rf_rs2, ex_fwd_rd, wb_rd, out_rd;
   logic [N-1:0] in_pc, in_imm, rf_rdata1, rf_rdata2, ex_fwd_data, wb_data;
   logic         ex_fwd_valid, wb_we, wb_is_load, flush, out_valid, out_ready, out_rd_we, out_is_load;
   logic [N-1:0] out_rs1_data, out_rs2_data, out_pc, out_imm;

   logic [N-1:0] rf [32];
   assign rf_rdata1 = rf[rf_rs1];
   assign rf_rdata2 = rf[rf_rs2];

   always #5 clk = ~clk;

   operand_fetch #(.N(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
      .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_pc(in_pc), .in_imm(in_imm),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_is_load(wb_is_load),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd(out_rd),
      .out_rd_we(out_rd_we), .out_is_load(out_is_load), .out_pc(out_pc), .out_imm(out_imm)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   logic         m_valid = 1'b0, m_rd_we = 1'b0, m_is_load = 1'b0;
   logic [N-1:0] m_rs1d = '0, m_rs2d = '0, m_pc = '0, m_imm = '0;
   logic [4:0]   m_rd = '0;
   bit           m_pend [32];
   logic         last_ready;

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] resolve(input logic [4:0] idx);
      if (idx == 0) return '0;
      if (ex_fwd_valid && ex_fwd_rd == idx) return ex_fwd_data;
      if (wb_we && wb_rd == idx) return wb_data;
      return rf[idx];
   endfunction

   function automatic logic blocked(input logic en, input logic [4:0] idx);
      if (!en || idx == 0) return 1'b0;
      if (m_pend[idx] && !(wb_we && wb_is_load && wb_rd == idx)) return 1'b1;
      return m_valid && m_rd_we && m_rd == idx;
   endfunction

   // one clock: check combinational outputs, advance the model, check registered outputs
   task automatic cyc();
      logic exp_ready, fire, do_wr;
      logic [4:0]   wr_idx;
      logic [N-1:0] wr_dat;
      #1;
      exp_ready = !rst && !flush && !blocked(in_rs1_en, in_rs1) && !blocked(in_rs2_en, in_rs2)
                  && (!m_valid || out_ready);
      last_ready = in_ready;
      chk("in_ready", N'(in_ready), N'(exp_ready));
      chk("rf_rs1", N'(rf_rs1), N'(in_rs1));
      chk("rf_rs2", N'(rf_rs2), N'(in_rs2));
      if (rst) begin
         m_valid = 0; m_rs1d = '0; m_rs2d = '0; m_rd = '0; m_rd_we = 0; m_is_load = 0;
         m_pc = '0; m_imm = '0;
         foreach (m_pend[i]) m_pend[i] = 0;
      end else begin
         fire = m_valid && out_ready && !flush;
         if (wb_we && wb_is_load) m_pend[wb_rd] = 0;
         if (fire && m_is_load && m_rd_we && m_rd != 0) m_pend[m_rd] = 1;
         if (flush) m_valid = 0;
         else if (in_valid && exp_ready) begin
            m_valid = 1; m_rs1d = resolve(in_rs1); m_rs2d = resolve(in_rs2);
            m_rd = in_rd; m_rd_we = in_rd_we; m_is_load = in_is_load; m_pc = in_pc; m_imm = in_imm;
         end else if (out_ready) m_valid = 0;
      end
      do_wr = wb_we && wb_rd != 0; wr_idx = wb_rd; wr_dat = wb_data;
      @(posedge clk);
      if (do_wr) rf[wr_idx] = wr_dat;
      #1;
      chk("out_valid", N'(out_valid), N'(m_valid));
      chk("out_rs1_data", out_rs1_data, m_rs1d);
      chk("out_rs2_data", out_rs2_data, m_rs2d);
      chk("out_rd", N'(out_rd), N'(m_rd));
      chk("out_rd_we", N'(out_rd_we), N'(m_rd_we));
      chk("out_is_load", N'(out_is_load), N'(m_is_load));
      chk("out_pc", out_pc, m_pc);
      chk("out_imm", out_imm, m_imm);
   endtask

   task automatic idle();
      rst = 0; flush = 0; out_ready = 1;
      in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_en = 0; in_rs2_en = 0;
      in_rd = 0; in_rd_we = 0; in_is_load = 0; in_pc = '0; in_imm = '0;
      ex_fwd_valid = 0; ex_fwd_rd = 0; ex_fwd_data = '0;
      wb_we = 0; wb_rd = 0; wb_data = '0; wb_is_load = 0;
   endtask

   task automatic instr(input logic [4:0] rs1, input logic e1, input logic [4:0] rs2, input logic e2,
                        input logic [4:0] rd, input logic we, input logic ld, input logic [N-1:0] pc);
      in_valid = 1; in_rs1 = rs1; in_rs1_en = e1; in_rs2 = rs2; in_rs2_en = e2;
      in_rd = rd; in_rd_we = we; in_is_load = ld; in_pc = pc; in_imm = pc + 32'h4;
   endtask

   initial begin
      foreach (rf[i]) rf[i] = $urandom;
      rf[0] = 32'hBAD0BAD0;
      foreach (m_pend[i]) m_pend[i] = 0;
      idle();
      rst = 1;
      cyc(); cyc();
      chk("reset_valid", N'(out_valid), '0);
      chk("reset_ready", N'(last_ready), '0);
      rst = 0;

      // 1: plain regfile read
      rf[3] = 32'd7; rf[4] = 32'd9;
      instr(3, 1, 4, 1, 10, 1, 0, 32'h100);
      cyc();
      chk("t1_valid", N'(out_valid), 32'd1);
      chk("t1_rs1", out_rs1_data, 32'd7);
      chk("t1_rs2", out_rs2_data, 32'd9);

      // 2: WB bypass of a same-cycle write
      instr(5, 1, 0, 0, 11, 1, 0, 32'h200);
      wb_we = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
      cyc();
      chk("t2_bypass", out_rs1_data, 32'hDEADBEEF);

      // 3: x0 ignores forwarding and bypass
      instr(0, 1, 0, 0, 12, 1, 0, 32'h300);
      wb_we = 1; wb_rd = 0; wb_data = 32'h1234;
      ex_fwd_valid = 1; ex_fwd_rd = 0; ex_fwd_data = 32'hFFFF;
      cyc();
      chk("t3_x0", out_rs1_data, 32'd0);

      // 4: load-use stall until the load writes back
      idle();
      instr(0, 0, 0, 0, 7, 1, 1, 32'h400);
      cyc();
      instr(0, 0, 7, 1, 13, 0, 0, 32'h410);
      cyc(); chk("t4_stall_inflight", N'(last_ready), '0);
      cyc(); chk("t4_stall_pending", N'(last_ready), '0);
      wb_we = 1; wb_rd = 7; wb_data = 32'h55; wb_is_load = 1;
      cyc(); chk("t4_accept", N'(last_ready), 32'd1);
      chk("t4_rs2", out_rs2_data, 32'h55);
      idle();
      instr(7, 1, 0, 0, 14, 0, 0, 32'h47);
      cyc(); chk("t4_pending_clear", N'(last_ready), 32'd1);

      // 5: backpressure holds ID/EX stable
      instr(1, 1, 0, 0, 15, 0, 0, 32'h500);
      out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("t5_hold_ready", N'(last_ready), '0);
         chk("t5_hold_pc", out_pc, 32'h47);
      end
      out_ready = 1;
      cyc();
      chk("t5_release_ready", N'(last_ready), 32'd1);
      chk("t5_release_pc", out_pc, 32'h500);

      // 6: flush of a load leaves pending alone; reset clears pending
      idle();
      instr(0, 0, 0, 0, 9, 1, 1, 32'h600);
      cyc();
      instr(0, 0, 0, 0, 6, 1, 1, 32'h610);
      cyc();
      idle(); flush = 1; out_ready = 0;
      cyc(); chk("t6_flush_valid", N'(out_valid), '0);
      idle();
      instr(6, 1, 0, 0, 16, 0, 0, 32'h620);
      cyc(); chk("t6_flushed_not_pending", N'(last_ready), 32'd1);
      instr(9, 1, 0, 0, 17, 0, 0, 32'h630);
      cyc(); chk("t6_pending_kept", N'(last_ready), '0);
      rst = 1;
      cyc(); chk("t6_rst_valid", N'(out_valid), '0);
      rst = 0;
      cyc(); chk("t6_rst_clears_pending", N'(last_ready), 32'd1);

      // randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         rst          = ($urandom_range(63) == 0);
         flush        = ($urandom_range(15) == 0);
         out_ready    = flush ? 1'b0 : ($urandom_range(3) != 0);
         in_valid     = ($urandom_range(3) != 0);
         in_rs1       = 5'($urandom_range(7));
         in_rs2       = 5'($urandom_range(7));
         in_rs1_en    = 1'($urandom);
         in_rs2_en    = 1'($urandom);
         in_rd        = 5'($urandom_range(7));
         in_rd_we     = 1'($urandom);
         in_is_load   = ($urandom_range(2) == 0);
         in_pc        = $urandom;
         in_imm       = $urandom;
         ex_fwd_valid = 1'($urandom);
         ex_fwd_rd    = 5'($urandom_range(7));
         ex_fwd_data  = $urandom;
         wb_we        = 1'($urandom);
         wb_rd        = 5'($urandom_range(7));
         wb_data      = $urandom;
         wb_is_load   = ($urandom_range(2) == 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
